// File: rtl/somador4bit_bist.sv
// Built-in self-test for the 4-bit adder: sweeps all 512 {a,b,cin} vectors, checks {cout,s}
// against a golden 5-bit sum and counts mismatches. Optional capture: SOMADOR_BIST_FIRST_FAIL_EN.
module somador4bit_bist #(
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_W         = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [3:0]       dut_s,
    input  logic             dut_cout,
    output logic [3:0]       dut_a,
    output logic [3:0]       dut_b,
    output logic             dut_cin,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [8:0]       vec_idx,
    output logic [13:0]      first_fail,
    output logic             first_fail_vld
);

    localparam int                WAIT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              run_active;
    logic              run_start;
    logic              run_abort;
    logic              wait_tc;
    logic              vec_last;
    logic [4:0]        golden;
    logic              mismatch;

    always_comb begin
        run_active = (state == S_DRIVE) || (state == S_WAIT) || (state == S_CHECK);
        // abort has priority over start, even outside a run
        run_start  = start && !abort && ((state == S_IDLE) || (state == S_DONE));
        run_abort  = abort && run_active;
        wait_tc    = (wait_cnt == '0);
        vec_last   = (vec_idx == 9'd511);
        golden     = {1'b0, dut_a} + {1'b0, dut_b} + {4'b0000, dut_cin};
        mismatch   = (golden != {dut_cout, dut_s});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (run_start) state_nxt = S_DRIVE;
            S_DRIVE: state_nxt = S_WAIT;
            S_WAIT:  if (wait_tc) state_nxt = S_CHECK;
            S_CHECK: state_nxt = vec_last ? S_DONE : S_DRIVE;
            S_DONE:  if (run_start) state_nxt = S_DRIVE;
            default: state_nxt = S_IDLE;
        endcase
        if (run_abort) begin
            state_nxt = S_IDLE;
        end
    end

    always_comb begin
        busy = run_active;
        done = (state == S_DONE);
        pass = done && (err_cnt == '0);
    end

    // an aborted cycle leaves every result register untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dut_a    <= 4'd0;
            dut_b    <= 4'd0;
            dut_cin  <= 1'b0;
            wait_cnt <= '0;
            err_cnt  <= '0;
            vec_idx  <= 9'd0;
        end else if (run_start) begin
            err_cnt <= '0;
            vec_idx <= 9'd0;
        end else if (!run_abort) begin
            case (state)
                S_DRIVE: begin
                    {dut_a, dut_b, dut_cin} <= vec_idx;
                    wait_cnt                <= WAIT_LOAD;
                end
                S_WAIT: begin
                    if (!wait_tc) begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end
                end
                S_CHECK: begin
                    if (mismatch && (err_cnt != ERR_MAX)) begin
                        err_cnt <= err_cnt + ERR_W'(1);
                    end
                    if (!vec_last) begin
                        vec_idx <= vec_idx + 9'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SOMADOR_BIST_FIRST_FAIL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_fail     <= 14'd0;
            first_fail_vld <= 1'b0;
        end else if (run_start) begin
            first_fail     <= 14'd0;
            first_fail_vld <= 1'b0;
        end else if ((state == S_CHECK) && !run_abort && mismatch && !first_fail_vld) begin
            first_fail     <= {dut_a, dut_b, dut_cin, dut_s, dut_cout};
            first_fail_vld <= 1'b1;
        end
    end
`else
    assign first_fail     = 14'd0;
    assign first_fail_vld = 1'b0;
`endif

endmodule
